// File: rtl/timer_pkg.sv
// Shared definitions for the BCD shot-clock family (count-up timer and countdown).
//   - state_t   : controller states
//   - TARGET_A/B: selectable BCD end values (24 / 30)
//   - SEG_*     : active-low seven-segment patterns, bit order gfedcba
//   - bcd_inc   : two-digit BCD increment
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] TARGET_A = 8'h24;
    localparam logic [7:0] TARGET_B = 8'h30;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // {msb,lsb} + 1 in BCD; the msb digit is never pushed past 9 by callers.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder (active-low, gfedcba).
// Ports:
//   bcd : input  [3:0] BCD digit
//   seg : output [6:0] segment pattern; codes 10-15 blank the display
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_upcount_timer.sv
// Two-digit BCD elapsed-time counter with seven-segment outputs.
// On start it latches a target (24 or 30), clears to 00 and counts up one
// step per CLK_DIV enabled cycles, then asserts done and holds the target.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset, highest priority
//   start   : one-cycle pulse, restarts from 00 in any state
//   enable  : level, counting advances only while high
//   select  : target select sampled on start (0 -> 24, 1 -> 30)
//   o1      : lsb digit segments, registered, active-low gfedcba
//   o2      : msb digit segments, registered, active-low gfedcba
//   running : high while in RUN
//   done    : high while in DONE
module bcd_upcount_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enable,
    input  logic       select,
    output logic [6:0] o1,
    output logic [6:0] o2,
    output logic       running,
    output logic       done
);

    localparam int unsigned     PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [3:0]       lsb_q, msb_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       target_q;
    logic             tick;
    logic [7:0]       count_inc;
    logic             hit;
    logic             running_d, done_d;
    logic [6:0]       seg_lsb, seg_msb;

    assign tick      = (state_q == RUN) && (pre_q == PRE_MAX);
    assign count_inc = bcd_inc({msb_q, lsb_q});
    assign hit       = (count_inc == target_q);

    // State register; running/done are registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= running_d;
            done    <= done_d;
        end
    end

    // Next-state logic. A tick that coincides with enable falling is still
    // counted; if that tick reaches the target, DONE wins over PAUSED.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = enable ? RUN : PAUSED;
        end else begin
            case (state_q)
                IDLE:   state_d = IDLE;
                RUN: begin
                    if (tick && hit) begin
                        state_d = DONE;
                    end else if (!enable) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: if (enable) state_d = RUN;
                DONE:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode of the next state (registered above).
    always_comb begin
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // Datapath: prescaler, digits and latched target.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_q    <= '0;
            msb_q    <= '0;
            pre_q    <= '0;
            target_q <= TARGET_A;
        end else if (start) begin
            lsb_q    <= '0;
            msb_q    <= '0;
            pre_q    <= '0;
            target_q <= select ? TARGET_B : TARGET_A;
        end else if (state_q == RUN) begin
            if (tick) begin
                pre_q          <= '0;
                {msb_q, lsb_q} <= count_inc;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    seg7_decode u_dec_lsb (
        .bcd (lsb_q),
        .seg (seg_lsb)
    );

    seg7_decode u_dec_msb (
        .bcd (msb_q),
        .seg (seg_msb)
    );

    // Segment outputs lag the digit registers by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o1 <= SEG_0;
            o2 <= SEG_0;
        end else begin
            o1 <= seg_lsb;
            o2 <= seg_msb;
        end
    end

endmodule

// File: tb/tb_bcd_upcount_timer.sv
// Directed self-checking bench for bcd_upcount_timer with CLK_DIV=4.
// Edge numbering in comments: En is the n-th rising edge after the edge
// that sampled start (E0); outputs are sampled 1 time unit after an edge.
module tb_bcd_upcount_timer;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst, start, enable, select;
    logic [6:0] o1, o2;
    logic       running, done;

    int n_cmp = 0;
    int n_err = 0;

    bcd_upcount_timer #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .enable  (enable),
        .select  (select),
        .o1      (o1),
        .o2      (o2),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [6:0] e2, input logic [6:0] e1);
        chk({tag, ".o2"}, {1'b0, o2}, {1'b0, e2});
        chk({tag, ".o1"}, {1'b0, o1}, {1'b0, e1});
    endtask

    task automatic chk_st(input string tag, input logic er, input logic ed);
        chk({tag, ".running"}, {7'd0, running}, {7'd0, er});
        chk({tag, ".done"},    {7'd0, done},    {7'd0, ed});
    endtask

    task automatic do_start(input logic sel);
        select = sel;
        start  = 1'b1;
        adv(1);
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; enable = 1'b0; select = 1'b0;
        adv(2);
        chk_disp("reset", S0, S0);
        chk_st("reset", 1'b0, 1'b0);
        rst = 1'b0;

        // Count to 24
        enable = 1'b1;
        do_start(1'b0);                      // E0
        adv(1);  chk_disp("c24_e1", S0, S0); chk_st("c24_e1", 1'b1, 1'b0);
        adv(3);  chk_disp("c24_e4_lag", S0, S0);
        adv(1);  chk_disp("c24_e5", S0, S1);
        adv(4);  chk_disp("c24_e9", S0, S2);
        adv(28); chk_disp("c24_09", S0, S9);   // E37
        adv(4);  chk_disp("c24_10", S1, S0);   // E41
        adv(54); chk_st("c24_e95", 1'b1, 1'b0);
        adv(1);  chk_st("c24_e96", 1'b0, 1'b1); chk_disp("c24_e96", S2, S3);
        adv(1);  chk_disp("c24_final", S2, S4);
        enable = 1'b0;
        adv(20); chk_disp("c24_hold", S2, S4); chk_st("c24_hold", 1'b0, 1'b1);

        // Restart from DONE, count to 30
        enable = 1'b1;
        do_start(1'b1);                      // F0
        chk_st("c30_f0", 1'b1, 1'b0);
        adv(1);  chk_disp("c30_f1", S0, S0);
        adv(36); chk_disp("c30_09", S0, S9);
        adv(4);  chk_disp("c30_10", S1, S0);
        adv(78); chk_st("c30_f119", 1'b1, 1'b0);
        adv(1);  chk_st("c30_f120", 1'b0, 1'b1);
        adv(1);  chk_disp("c30_final", S3, S0);
        adv(12); chk_disp("c30_hold", S3, S0); chk_st("c30_hold", 1'b0, 1'b1);

        // Pause and resume: prescaler phase is kept across the pause
        do_start(1'b0);                      // G0
        adv(21); chk_disp("pz_05", S0, S5);
        enable = 1'b0;
        adv(1);  chk_st("pz_paused", 1'b0, 1'b0);
        adv(10); chk_disp("pz_hold", S0, S5); chk_st("pz_hold", 1'b0, 1'b0);
        enable = 1'b1;
        adv(1);  chk_st("pz_resume", 1'b1, 1'b0);   // G33
        adv(2);  chk_disp("pz_g35", S0, S5);
        adv(1);  chk_disp("pz_06", S0, S6);         // G36
        // enable falls on a tick edge (G39): increment applied, then PAUSED
        adv(2);
        enable = 1'b0;
        adv(1);  chk_st("tickfall_st", 1'b0, 1'b0);
        adv(1);  chk_disp("tickfall_07", S0, S7);
        adv(5);  chk_disp("tickfall_hold", S0, S7);

        // Restart during RUN at 17 with select=1
        enable = 1'b1;
        do_start(1'b0);                      // H0
        adv(69); chk_disp("rs_17", S1, S7);
        do_start(1'b1);                      // I0
        adv(1);  chk_disp("rs_cleared", S0, S0); chk_st("rs_i1", 1'b1, 1'b0);
        adv(95); chk_st("rs_not24", 1'b1, 1'b0);
        adv(24); chk_st("rs_done30", 1'b0, 1'b1);
        adv(1);  chk_disp("rs_30", S3, S0);

        // Reset mid-run for 2 cycles
        do_start(1'b0);                      // J0
        adv(22);
        rst = 1'b1;
        adv(2);
        rst = 1'b0;
        chk_disp("rstmid", S0, S0); chk_st("rstmid", 1'b0, 1'b0);
        adv(20); chk_disp("rstmid_hold", S0, S0); chk_st("rstmid_hold", 1'b0, 1'b0);

        // rst and start together: reset wins, IDLE ignores enable
        enable = 1'b1; select = 1'b1;
        rst = 1'b1; start = 1'b1;
        adv(1);
        rst = 1'b0; start = 1'b0;
        chk_st("prec", 1'b0, 1'b0); chk_disp("prec", S0, S0);
        adv(8);  chk_st("prec_idle", 1'b0, 1'b0); chk_disp("prec_idle", S0, S0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
